// File: rtl/amm_mem_responder.sv
// Avalon-MM responder backed by a word-addressed, byte-lane RAM.
// Each transfer is held off for a programmable number of wait states, then
// accepted with a single-cycle waitrequest low. Read data returns after a
// programmable latency as a one-cycle readdatavalid pulse.
module amm_mem_responder #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int STRB_W       = DATA_W / 8,
  parameter int DEPTH        = 256,
  parameter int WAIT_CYCLES  = 2,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  input  logic [STRB_W-1:0] byteenable,
  output logic              waitrequest,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid,
  output logic              protocol_err
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_RESP} state_t;

  state_t             r_state;
  logic [3:0]         r_cnt;
  logic [3:0]         r_lat;
  logic [DATA_W-1:0]  r_hold;
  logic [DATA_W-1:0]  r_readdata;
  logic               r_waitrequest;
  logic               r_rdv;
  logic               r_perr;

  logic               w_req;
  logic               w_ack_wr;
  logic [IDX_W-1:0]   w_idx;
  logic [DATA_W-1:0]  w_rd_word;
  logic               w_unused_addr;

  assign w_req    = read | write;
  assign w_idx    = address[IDX_W-1:0];
  // A write wins over a simultaneous read, so any write at ACK commits.
  assign w_ack_wr = (r_state == S_ACK) && write;

  // Upper address bits only select aliases of the same RAM word.
  generate
    if (ADDR_W > IDX_W) begin : g_addr_hi
      assign w_unused_addr = ^address[ADDR_W-1:IDX_W];
    end else begin : g_addr_full
      assign w_unused_addr = 1'b0;
    end
  endgenerate

  // One RAM per byte lane so byteenable maps to independent lane write enables.
  // The reset term blocks a write on an edge where the transfer is being aborted.
  genvar gi;
  generate
    for (gi = 0; gi < STRB_W; gi++) begin : g_lane
      logic [7:0] r_mem [DEPTH];

      // Lane write on the accept edge of a write transfer.
      always_ff @(posedge clk) begin
        if (reset && w_ack_wr && byteenable[gi]) begin
          r_mem[w_idx] <= writedata[gi*8 +: 8];
        end
      end

      assign w_rd_word[gi*8 +: 8] = r_mem[w_idx];
    end
  endgenerate

  // Transfer sequencing: wait states, single-cycle accept, read latency pipe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_waitrequest <= 1'b1;
      r_rdv         <= 1'b0;
      r_readdata    <= '0;
      r_perr        <= 1'b0;
      r_cnt         <= '0;
      r_lat         <= '0;
      r_hold        <= '0;
    end else begin
      r_rdv         <= 1'b0;
      r_perr        <= 1'b0;
      r_waitrequest <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (WAIT_CYCLES == 0) begin
              r_state       <= S_ACK;
              r_waitrequest <= 1'b0;
            end else begin
              r_cnt   <= 4'(WAIT_CYCLES);
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!w_req) begin
            r_state <= S_IDLE;
          end else if (r_cnt == 4'd1) begin
            r_state       <= S_ACK;
            r_waitrequest <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_ACK: begin
          if (!w_req) begin
            r_state <= S_IDLE;
          end else if (write) begin
            r_perr  <= read;
            r_state <= S_IDLE;
          end else begin
            // Latency 1 means the response is visible in the very next cycle,
            // so the RAM word goes straight to the output register.
            if (READ_LATENCY == 1) begin
              r_readdata <= w_rd_word;
              r_rdv      <= 1'b1;
              r_lat      <= '0;
            end else begin
              r_hold <= w_rd_word;
              r_lat  <= 4'(READ_LATENCY - 1);
            end
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          // r_lat == 0 marks the cycle in which the response pulse is showing.
          if (r_lat == 4'd0) begin
            r_state <= S_IDLE;
          end else begin
            if (r_lat == 4'd1) begin
              r_readdata <= r_hold;
              r_rdv      <= 1'b1;
            end
            r_lat <= r_lat - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign waitrequest   = r_waitrequest;
  assign readdata      = r_readdata;
  assign readdatavalid = r_rdv;
  assign protocol_err  = r_perr;

endmodule

// File: tb/tb_amm_mem_responder.sv
// Bench for amm_mem_responder: two instances (default timing, and zero wait
// states with read latency 4) driven by directed and random transfers,
// checked against a word-array memory model and closed-form timing.
module tb_amm_mem_responder;

  logic        clk;
  logic        b_reset      [2];
  logic [15:0] b_address    [2];
  logic        b_read       [2];
  logic        b_write      [2];
  logic [31:0] b_writedata  [2];
  logic [3:0]  b_byteenable [2];
  logic        b_waitreq    [2];
  logic [31:0] b_readdata   [2];
  logic        b_rdv        [2];
  logic        b_perr       [2];

  int wc  [2] = '{2, 0};
  int lat [2] = '{1, 4};

  logic [31:0] mem_m [2][256];

  int checks = 0;
  int errors = 0;

  amm_mem_responder u_dut0 (
    .clk(clk), .reset(b_reset[0]), .address(b_address[0]), .read(b_read[0]),
    .write(b_write[0]), .writedata(b_writedata[0]), .byteenable(b_byteenable[0]),
    .waitrequest(b_waitreq[0]), .readdata(b_readdata[0]),
    .readdatavalid(b_rdv[0]), .protocol_err(b_perr[0])
  );

  amm_mem_responder #(.WAIT_CYCLES(0), .READ_LATENCY(4)) u_dut1 (
    .clk(clk), .reset(b_reset[1]), .address(b_address[1]), .read(b_read[1]),
    .write(b_write[1]), .writedata(b_writedata[1]), .byteenable(b_byteenable[1]),
    .waitrequest(b_waitreq[1]), .readdata(b_readdata[1]),
    .readdatavalid(b_rdv[1]), .protocol_err(b_perr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return res;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One complete transfer on instance k, starting from an idle DUT.
  task automatic xfer(input int k, input bit do_rd, input bit do_wr, input logic [15:0] a,
                      input logic [31:0] d, input logic [3:0] be, input string tag,
                      output logic [31:0] got);
    int w;
    int l;
    logic [31:0] exp_rd;
    logic [7:0] idx;
    w   = wc[k];
    l   = lat[k];
    idx = a[7:0];
    got = 'x;
    b_address[k]    = a;
    b_writedata[k]  = d;
    b_byteenable[k] = be;
    b_read[k]       = do_rd;
    b_write[k]      = do_wr;
    for (int n = 1; n <= w + 1; n++) begin
      step();
      chk($sformatf("%s wreq c%0d", tag, n), 32'(b_waitreq[k]), (n == w + 1) ? 32'd0 : 32'd1);
    end
    exp_rd = mem_m[k][idx];
    if (do_wr) mem_m[k][idx] = merge(mem_m[k][idx], d, be);
    step();
    b_read[k]  = 1'b0;
    b_write[k] = 1'b0;
    chk({tag, " perr"}, 32'(b_perr[k]), 32'(do_rd && do_wr));
    chk({tag, " wreq_after"}, 32'(b_waitreq[k]), 32'd1);
    if (do_rd && !do_wr) begin
      for (int m = 1; m <= l; m++) begin
        if (m > 1) step();
        chk($sformatf("%s rdv m%0d", tag, m), 32'(b_rdv[k]), (m == l) ? 32'd1 : 32'd0);
      end
      got = b_readdata[k];
      chk({tag, " rdata"}, b_readdata[k], exp_rd);
      step();
      chk({tag, " rdv_end"}, 32'(b_rdv[k]), 32'd0);
      chk({tag, " rdata_hold"}, b_readdata[k], exp_rd);
    end else begin
      chk({tag, " no_rdv"}, 32'(b_rdv[k]), 32'd0);
    end
    $display("xfer %-12s inst=%0d rd=%0d wr=%0d addr=%h wdata=%h be=%b rdata=%h",
             tag, k, do_rd, do_wr, a, d, be, got);
  endtask

  logic [31:0] got;

  initial begin
    for (int k = 0; k < 2; k++) begin
      b_reset[k] = 1'b0; b_address[k] = '0; b_read[k] = 1'b0; b_write[k] = 1'b0;
      b_writedata[k] = '0; b_byteenable[k] = '0;
    end
    repeat (3) step();
    b_reset[0] = 1'b1;
    b_reset[1] = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst wreq%0d", k), 32'(b_waitreq[k]), 32'd1);
      chk($sformatf("rst rdv%0d", k), 32'(b_rdv[k]), 32'd0);
      chk($sformatf("rst rdata%0d", k), b_readdata[k], 32'd0);
      chk($sformatf("rst perr%0d", k), 32'(b_perr[k]), 32'd0);
    end

    // Basic write then read.
    xfer(0, 0, 1, 16'h0010, 32'hDEADBEEF, 4'hF, "t1_wr", got);
    xfer(0, 1, 0, 16'h0010, 32'h0, 4'h0, "t1_rd", got);
    chk("t1 const", got, 32'hDEADBEEF);

    // Partial byte write.
    xfer(0, 0, 1, 16'h0004, 32'h11223344, 4'hF, "t2_wr1", got);
    xfer(0, 0, 1, 16'h0004, 32'hAABBCCDD, 4'b0101, "t2_wr2", got);
    xfer(0, 1, 0, 16'h0004, 32'h0, 4'h0, "t2_rd", got);
    chk("t2 const", got, 32'h11BB33DD);

    // byteenable==0 leaves the word unchanged.
    xfer(0, 0, 1, 16'h0004, 32'hFFFFFFFF, 4'b0000, "t2_be0", got);
    xfer(0, 1, 0, 16'h0004, 32'h0, 4'h0, "t2_rd0", got);
    chk("t2 be0 const", got, 32'h11BB33DD);

    // Zero wait states, latency 4.
    xfer(1, 0, 1, 16'h0010, 32'hDEADBEEF, 4'hF, "t3_wr", got);
    xfer(1, 1, 0, 16'h0010, 32'h0, 4'h0, "t3_rd", got);
    chk("t3 const", got, 32'hDEADBEEF);

    // Address wrap.
    xfer(0, 0, 1, 16'h0105, 32'hCAFEF00D, 4'hF, "t4_wr", got);
    xfer(0, 1, 0, 16'h0005, 32'h0, 4'h0, "t4_rd", got);
    chk("t4 const", got, 32'hCAFEF00D);

    // Simultaneous read and write.
    xfer(0, 1, 1, 16'h0020, 32'h5A5A5A5A, 4'hF, "t5_rw", got);
    xfer(0, 1, 0, 16'h0020, 32'h0, 4'h0, "t5_rd", got);
    chk("t5 const", got, 32'h5A5A5A5A);

    // Reset during RESP on the latency-4 instance.
    b_address[1] = 16'h0010;
    b_read[1]    = 1'b1;
    step();
    chk("t6 ack", 32'(b_waitreq[1]), 32'd0);
    step();
    b_read[1] = 1'b0;
    chk("t6 resp_rdv", 32'(b_rdv[1]), 32'd0);
    b_reset[1] = 1'b0;
    step();
    chk("t6 rst_wreq", 32'(b_waitreq[1]), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t6 rst_rdv%0d", i), 32'(b_rdv[1]), 32'd0);
      if (i == 1) b_reset[1] = 1'b1;
      step();
    end
    chk("t6 rdata_cleared", b_readdata[1], 32'd0);
    xfer(1, 1, 0, 16'h0010, 32'h0, 4'h0, "t6_rd", got);
    chk("t6 const", got, 32'hDEADBEEF);

    // Reset during ACK of a write: RAM must keep the old word.
    xfer(0, 0, 1, 16'h0030, 32'h01010101, 4'hF, "t7_wr", got);
    b_address[0] = 16'h0030; b_writedata[0] = 32'hFFFFFFFF; b_byteenable[0] = 4'hF;
    b_write[0]   = 1'b1;
    repeat (wc[0] + 1) step();
    chk("t7 ack", 32'(b_waitreq[0]), 32'd0);
    b_reset[0] = 1'b0;
    step();
    b_write[0] = 1'b0;
    b_reset[0] = 1'b1;
    chk("t7 rst_wreq", 32'(b_waitreq[0]), 32'd1);
    step();
    xfer(0, 1, 0, 16'h0030, 32'h0, 4'h0, "t7_rd", got);
    chk("t7 const", got, 32'h01010101);

    // Request dropped during WAIT: no accept, no RAM effect.
    b_address[0] = 16'h0030; b_writedata[0] = 32'h77777777; b_write[0] = 1'b1;
    step();
    b_write[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t8 drop_wreq%0d", i), 32'(b_waitreq[0]), 32'd1);
      step();
    end
    xfer(0, 1, 0, 16'h0030, 32'h0, 4'h0, "t8_rd", got);
    chk("t8 const", got, 32'h01010101);

    // Random traffic over a preloaded window, upper address bits randomised.
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++)
        xfer(k, 0, 1, {8'($urandom), 8'(8'h40 + i)}, $urandom, 4'hF, "init", got);
    for (int t = 0; t < 40; t++) begin
      int k;
      int op;
      k  = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 9));
      if (op < 5)
        xfer(k, 1, 0, {8'($urandom), 8'(8'h40 + $urandom_range(0, 15))}, 32'h0, 4'h0, "rnd_rd", got);
      else if (op < 9)
        xfer(k, 0, 1, {8'($urandom), 8'(8'h40 + $urandom_range(0, 15))}, $urandom,
             4'($urandom), "rnd_wr", got);
      else
        xfer(k, 1, 1, {8'($urandom), 8'(8'h40 + $urandom_range(0, 15))}, $urandom,
             4'($urandom), "rnd_rw", got);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
